// File: rtl/lbus_cmd_decoder.sv
// ---------------------------------------------------------------------------
// lbus_cmd_decoder
//
// Main-FPGA end of the local bus. The controller FPGA streams host bytes in
// on lbus_wd/lbus_we; this block parses SASEBO-GII style commands and turns
// them into 16-bit register write/read strobes for the cipher core. Data
// read back from the core is queued high byte first in a small
// first-word-fall-through FIFO that the controller drains through
// lbus_rd/lbus_emp/lbus_re. Everything runs on the local bus clock.
//
// Command format:
//   write : 0x01, addrH, addrL, dataH, dataL
//   read  : 0x00, addrH, addrL
//
// Parameters:
//   DEPTH   read-back FIFO depth in bytes (power of 2, >= 2)
//   RD_LAT  cycles from the blk_rd pulse until blk_rdata is sampled (1..15)
//   TIMEOUT idle cycles before a half-received command is abandoned
//
// Build option:
//   LBUS_TIMEOUT_EN  when defined, an idle counter aborts incomplete commands
//                    after TIMEOUT cycles (sets err, no strobe). Without it
//                    the parser waits indefinitely for the remaining bytes.
//
// Ports:
//   CLK        local bus clock
//   RST        synchronous reset, active high
//   lbus_wd    write byte from controller
//   lbus_we    write byte valid (one byte per cycle)
//   lbus_ful   do-not-write flag
//   lbus_rd    FIFO head byte (0x00 when empty)
//   lbus_re    pop FIFO head
//   lbus_emp   FIFO empty
//   blk_addr   register address
//   blk_wdata  register write data
//   blk_wr     one-cycle write strobe
//   blk_rd     one-cycle read strobe
//   blk_rdata  register read data
//   err        sticky protocol error (cleared only by RST)
// ---------------------------------------------------------------------------
module lbus_cmd_decoder #(
  parameter int DEPTH   = 4,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  lbus_wd,
  input  logic        lbus_we,
  output logic        lbus_ful,
  output logic [7:0]  lbus_rd,
  input  logic        lbus_re,
  output logic        lbus_emp,
  output logic [15:0] blk_addr,
  output logic [15:0] blk_wdata,
  output logic        blk_wr,
  output logic        blk_rd,
  input  logic [15:0] blk_rdata,
  output logic        err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0]       CMD_READ  = 8'h00;
  localparam logic [7:0]       CMD_WRITE = 8'h01;
  localparam logic [3:0]       WAIT_LAST = 4'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] FUL_LEVEL = CNT_W'(DEPTH - 2);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lbus_cmd_decoder: DEPTH must be a power of 2 and at least 2");
  end
  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("lbus_cmd_decoder: RD_LAT must be in 1..15");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("lbus_cmd_decoder: TIMEOUT must be at least 1");
  end

  typedef enum logic [3:0] {
    IDLE,
    W_AH,
    W_AL,
    W_DH,
    W_DL,
    W_EXEC,
    R_AH,
    R_AL,
    R_EXEC,
    R_WAIT,
    R_PUSH_H,
    R_PUSH_L
  } state_t;

  state_t state_reg;

  // Partial command bytes; only committed to blk_* once a command completes,
  // so an aborted command never disturbs the held address/data.
  logic [7:0]  addr_h_reg;
  logic [7:0]  addr_l_reg;
  logic [7:0]  data_h_reg;
  logic [15:0] rdata_reg;
  logic [3:0]  wait_cnt_reg;

  logic [15:0] blk_addr_reg;
  logic [15:0] blk_wdata_reg;
  logic        blk_wr_reg;
  logic        blk_rd_reg;
  logic        err_reg;

  // Read-back FIFO
  logic [7:0]       mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic       rd_busy;
  logic       byte_acc;
  logic       byte_drop;
  logic       push_en;
  logic [7:0] push_byte;
  logic       pop_en;
  logic       timeout_hit;

  // While a read is in flight the bus is held off, and it is also held off
  // whenever fewer than two free slots remain, so a read that is allowed to
  // start can always push both of its bytes.
  assign rd_busy   = (state_reg == R_EXEC) || (state_reg == R_WAIT) ||
                     (state_reg == R_PUSH_H) || (state_reg == R_PUSH_L);
  assign lbus_ful  = rd_busy || (count_reg > FUL_LEVEL);
  assign byte_acc  = lbus_we && !lbus_ful;
  assign byte_drop = lbus_we && lbus_ful;

  // No full check needed on push: room for both bytes was reserved above.
  assign push_en   = (state_reg == R_PUSH_H) || (state_reg == R_PUSH_L);
  assign push_byte = (state_reg == R_PUSH_H) ? rdata_reg[15:8] : rdata_reg[7:0];
  assign pop_en    = lbus_re && (count_reg != '0);

  assign lbus_emp  = (count_reg == '0);
  assign lbus_rd   = lbus_emp ? 8'h00 : mem_reg[rd_ptr_reg];

  assign blk_addr  = blk_addr_reg;
  assign blk_wdata = blk_wdata_reg;
  assign blk_wr    = blk_wr_reg;
  assign blk_rd    = blk_rd_reg;
  assign err       = err_reg;

`ifdef LBUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_reg;
  logic            in_cmd;

  // Only the byte-collecting states can stall on the host; the exec/read
  // states always make progress on their own.
  assign in_cmd = (state_reg == W_AH) || (state_reg == W_AL) ||
                  (state_reg == W_DH) || (state_reg == W_DL) ||
                  (state_reg == R_AH) || (state_reg == R_AL);

  // The counter holds the number of idle cycles already spent in the current
  // state, so the abort fires on the TIMEOUT-th consecutive idle cycle.
  assign timeout_hit = in_cmd && !byte_acc && (to_cnt_reg == TO_LAST);

  always_ff @(posedge CLK) begin
    if (RST || !in_cmd || byte_acc) begin
      to_cnt_reg <= '0;
    end else if (!timeout_hit) begin
      to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Command parser
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      addr_h_reg    <= '0;
      addr_l_reg    <= '0;
      data_h_reg    <= '0;
      rdata_reg     <= '0;
      wait_cnt_reg  <= '0;
      blk_addr_reg  <= '0;
      blk_wdata_reg <= '0;
      blk_wr_reg    <= 1'b0;
      blk_rd_reg    <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      blk_wr_reg <= 1'b0;
      blk_rd_reg <= 1'b0;

      if (byte_drop || timeout_hit) begin
        err_reg <= 1'b1;
      end

      if (timeout_hit) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          // W_EXEC behaves like IDLE so a command can follow a write
          // back-to-back without a dead cycle.
          IDLE, W_EXEC: begin
            state_reg <= IDLE;
            if (byte_acc) begin
              if (lbus_wd == CMD_WRITE) begin
                state_reg <= W_AH;
              end else if (lbus_wd == CMD_READ) begin
                state_reg <= R_AH;
              end else begin
                err_reg <= 1'b1;
              end
            end
          end

          W_AH: begin
            if (byte_acc) begin
              addr_h_reg <= lbus_wd;
              state_reg  <= W_AL;
            end
          end

          W_AL: begin
            if (byte_acc) begin
              addr_l_reg <= lbus_wd;
              state_reg  <= W_DH;
            end
          end

          W_DH: begin
            if (byte_acc) begin
              data_h_reg <= lbus_wd;
              state_reg  <= W_DL;
            end
          end

          W_DL: begin
            if (byte_acc) begin
              blk_addr_reg  <= {addr_h_reg, addr_l_reg};
              blk_wdata_reg <= {data_h_reg, lbus_wd};
              blk_wr_reg    <= 1'b1;
              state_reg     <= W_EXEC;
            end
          end

          R_AH: begin
            if (byte_acc) begin
              addr_h_reg <= lbus_wd;
              state_reg  <= R_AL;
            end
          end

          R_AL: begin
            if (byte_acc) begin
              blk_addr_reg <= {addr_h_reg, lbus_wd};
              blk_rd_reg   <= 1'b1;
              state_reg    <= R_EXEC;
            end
          end

          // With RD_LAT == 1 there is no wait state and the data is taken on
          // the edge that ends the strobe cycle.
          R_EXEC: begin
            if (WAIT_LAST == 4'd0) begin
              rdata_reg <= blk_rdata;
              state_reg <= R_PUSH_H;
            end else begin
              wait_cnt_reg <= 4'd1;
              state_reg    <= R_WAIT;
            end
          end

          R_WAIT: begin
            if (wait_cnt_reg == WAIT_LAST) begin
              rdata_reg <= blk_rdata;
              state_reg <= R_PUSH_H;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
          end

          R_PUSH_H: state_reg <= R_PUSH_L;
          R_PUSH_L: state_reg <= IDLE;

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read-back FIFO (pointers wrap naturally since DEPTH is a power of 2)
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (push_en) begin
      mem_reg[wr_ptr_reg] <= push_byte;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_lbus_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_lbus_cmd_decoder
//
// Directed bench for lbus_cmd_decoder (DEPTH=4, RD_LAT=2, TIMEOUT=16).
// Inputs are driven on the falling edge and outputs are checked on the
// falling edge, half a cycle after the DUT updates. A small register slave
// returns slave_val on blk_rdata from the cycle after each blk_rd strobe.
// ---------------------------------------------------------------------------
module tb_lbus_cmd_decoder;

  localparam int DEPTH   = 4;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 16;

  logic        CLK;
  logic        RST;
  logic [7:0]  lbus_wd;
  logic        lbus_we;
  logic        lbus_ful;
  logic [7:0]  lbus_rd;
  logic        lbus_re;
  logic        lbus_emp;
  logic [15:0] blk_addr;
  logic [15:0] blk_wdata;
  logic        blk_wr;
  logic        blk_rd;
  logic [15:0] blk_rdata;
  logic        err;

  int          vec_cnt = 0;
  int          mis_cnt = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [15:0] last_rd_addr = '0;
  logic [15:0] slave_val = 16'h0000;
  int          wr_base;
  int          rd_base;

  lbus_cmd_decoder #(
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .lbus_wd  (lbus_wd),
    .lbus_we  (lbus_we),
    .lbus_ful (lbus_ful),
    .lbus_rd  (lbus_rd),
    .lbus_re  (lbus_re),
    .lbus_emp (lbus_emp),
    .blk_addr (blk_addr),
    .blk_wdata(blk_wdata),
    .blk_wr   (blk_wr),
    .blk_rd   (blk_rd),
    .blk_rdata(blk_rdata),
    .err      (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register slave: data becomes valid the cycle after the strobe and holds.
  always @(posedge CLK) begin
    if (RST) begin
      blk_rdata <= 16'hDEAD;
    end else if (blk_rd) begin
      blk_rdata <= slave_val;
    end
  end

  // Strobe monitor
  always @(posedge CLK) begin
    if (blk_wr) begin
      wr_cnt <= wr_cnt + 1;
    end
    if (blk_rd) begin
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= blk_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    lbus_we = 1'b1;
    lbus_wd = b;
    @(negedge CLK);
    lbus_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pop();
    lbus_re = 1'b1;
    @(negedge CLK);
    lbus_re = 1'b0;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
  endtask

  // Full read transaction; returns once both bytes are in the FIFO.
  task automatic do_read(input logic [15:0] addr, input logic [15:0] val);
    slave_val = val;
    send_byte(8'h00);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    idle(4);
    $display("read  [%04h] -> %04h", addr, val);
  endtask

  initial begin
    RST     = 1'b1;
    lbus_wd = 8'h00;
    lbus_we = 1'b0;
    lbus_re = 1'b0;
    @(negedge CLK);
    do_reset(2);

    // ---------------- reset state ----------------
    $display("reset");
    chk("rst_emp",   lbus_emp,  1);
    chk("rst_ful",   lbus_ful,  0);
    chk("rst_rd",    lbus_rd,   8'h00);
    chk("rst_addr",  blk_addr,  16'h0000);
    chk("rst_wdata", blk_wdata, 16'h0000);
    chk("rst_wr",    blk_wr,    0);
    chk("rst_rdstb", blk_rd,    0);
    chk("rst_err",   err,       0);

    // ---------------- write ----------------
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAB); send_byte(8'hCD);
    $display("write [1234] <= abcd");
    chk("wr_strobe", blk_wr,    1);
    chk("wr_addr",   blk_addr,  16'h1234);
    chk("wr_data",   blk_wdata, 16'hABCD);
    @(negedge CLK);
    chk("wr_strobe_end", blk_wr,    0);
    chk("wr_addr_hold",  blk_addr,  16'h1234);
    chk("wr_data_hold",  blk_wdata, 16'hABCD);
    chk("wr_count",      wr_cnt,    1);
    chk("wr_err",        err,       0);

    // ---------------- read, cycle by cycle ----------------
    slave_val = 16'h5A3C;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    $display("read  [000c] -> 5a3c");
    chk("rd_strobe", blk_rd,   1);
    chk("rd_addr",   blk_addr, 16'h000C);
    for (int i = 0; i < 4; i++) begin
      chk("rd_ful_busy", lbus_ful, 1);
      if (i == 1) chk("rd_strobe_end", blk_rd, 0);
      if (i == 2) chk("rd_emp_before", lbus_emp, 1);
      if (i == 3) chk("rd_head_first", lbus_rd, 8'h5A);
      @(negedge CLK);
    end
    chk("rd_ful_done", lbus_ful, 0);
    chk("rd_emp_done", lbus_emp, 0);
    chk("rd_hi",       lbus_rd,  8'h5A);
    pop();
    chk("rd_lo",       lbus_rd,  8'h3C);
    chk("rd_emp_mid",  lbus_emp, 0);
    pop();
    chk("rd_emp_end",  lbus_emp, 1);
    chk("rd_rd_end",   lbus_rd,  8'h00);
    chk("rd_count",    rd_cnt,   1);
    chk("rd_wr_count", wr_cnt,   1);
    chk("rd_err",      err,      0);

    // ---------------- bad command ----------------
    send_byte(8'h07);
    idle(1);
    $display("bad command 07");
    chk("bad_err", err,      1);
    chk("bad_emp", lbus_emp, 1);
    chk("bad_ful", lbus_ful, 0);

    // ---------------- overflow ----------------
    do_reset(1);
    do_read(16'h0010, 16'h1122);
    chk("ovf_ful_first", lbus_ful, 0);
    do_read(16'h0011, 16'h3344);
    chk("ovf_ful_second", lbus_ful, 1);
    chk("ovf_err_before", err,     0);
    wr_base = wr_cnt;
    send_byte(8'h01);
    idle(2);
    $display("dropped byte 01 while full");
    chk("ovf_err_drop", err,      1);
    chk("ovf_ful_hold", lbus_ful, 1);
    chk("ovf_no_wr",    wr_cnt,   wr_base);
    chk("ovf_b0", lbus_rd, 8'h11); pop();
    chk("ovf_b1", lbus_rd, 8'h22); pop();
    chk("ovf_b2", lbus_rd, 8'h33); pop();
    chk("ovf_b3", lbus_rd, 8'h44); pop();
    chk("ovf_emp", lbus_emp, 1);
    chk("ovf_ful_end", lbus_ful, 0);

    // ---------------- push and pop in the same cycle ----------------
    do_reset(1);
    do_read(16'h0020, 16'h6677);
    slave_val = 16'h8899;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h21);
    idle(2);
    chk("pp_head_before", lbus_rd, 8'h66);
    pop();                       // coincides with the high-byte push
    $display("read  [0021] -> 8899 with pop on push");
    chk("pp_head_after", lbus_rd,  8'h77);
    chk("pp_emp",        lbus_emp, 0);
    idle(1);
    chk("pp_ful_three",  lbus_ful, 1);
    chk("pp_b0", lbus_rd, 8'h77); pop();
    chk("pp_b1", lbus_rd, 8'h88); pop();
    chk("pp_b2", lbus_rd, 8'h99); pop();
    chk("pp_emp_end", lbus_emp, 1);
    pop();                       // underflow attempt
    $display("pop while empty");
    chk("uf_emp", lbus_emp, 1);
    chk("uf_rd",  lbus_rd,  8'h00);
    chk("uf_err", err,      0);
    do_read(16'h0022, 16'hBEEF);
    chk("uf_b0", lbus_rd, 8'hBE); pop();
    chk("uf_b1", lbus_rd, 8'hEF); pop();
    chk("uf_emp_end", lbus_emp, 1);

    // ---------------- reset mid-command ----------------
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    do_reset(1);
    $display("reset mid-command");
    do_read(16'h0002, 16'h0102);
    chk("mid_no_wr",   wr_cnt,       wr_base);
    chk("mid_rd_cnt",  rd_cnt,       rd_base + 1);
    chk("mid_rd_addr", last_rd_addr, 16'h0002);
    chk("mid_addr",    blk_addr,     16'h0002);
    chk("mid_b0", lbus_rd, 8'h01); pop();
    chk("mid_b1", lbus_rd, 8'h02); pop();
    chk("mid_err", err, 0);

    // ---------------- stalled command ----------------
    do_reset(1);
    wr_base = wr_cnt;
    rd_base = rd_cnt;
    send_byte(8'h01); send_byte(8'h12);
`ifdef LBUS_TIMEOUT_EN
    idle(TIMEOUT - 1);
    chk("to_err_early", err, 0);
    idle(1);
    $display("timeout after 01 12");
    chk("to_err", err, 1);
    chk("to_no_wr", wr_cnt, wr_base);
    do_read(16'h0004, 16'h4455);
    chk("to_rd_cnt",  rd_cnt,       rd_base + 1);
    chk("to_rd_addr", last_rd_addr, 16'h0004);
    chk("to_b0", lbus_rd, 8'h44); pop();
    chk("to_b1", lbus_rd, 8'h55); pop();
    chk("to_wr_cnt", wr_cnt, wr_base);
`else
    idle(TIMEOUT + 4);
    chk("stall_err", err, 0);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    $display("write [1234] <= 5678 after long stall");
    chk("stall_wr",    blk_wr,    1);
    chk("stall_addr",  blk_addr,  16'h1234);
    chk("stall_wdata", blk_wdata, 16'h5678);
    idle(1);
    do_read(16'h0004, 16'h4455);
    chk("stall_rd_addr", last_rd_addr, 16'h0004);
    chk("stall_b0", lbus_rd, 8'h44); pop();
    chk("stall_b1", lbus_rd, 8'h55); pop();
    chk("stall_wr_cnt", wr_cnt, wr_base + 1);
`endif
    chk("final_emp", lbus_emp, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/lbus_cmd_decoder.md
Name: lbus_cmd_decoder

Overview:
- Main-FPGA side of the local bus driven by the controller FPGA's cipher interface.
- Receives the host byte stream (lbus_wd/lbus_we) and parses SASEBO-GII style commands into 16-bit register write and read strobes toward the cipher core.
- Buffers read-back bytes in a small FIFO presented as lbus_rd/lbus_emp/lbus_re.
- Runs entirely in the lbus_clk domain.

Parameters:
- DEPTH, 4, read-back FIFO depth in bytes; power of 2, at least 2.
- RD_LAT, 2, cycles from blk_rd pulse to blk_rdata valid; range 1..15.
- TIMEOUT, 1024, idle cycles before an incomplete command is aborted. Used only with LBUS_TIMEOUT_EN.

Ports:
- CLK  in  1  local bus clock (lbus_clk).
- RST  in  1  synchronous reset, active-high.
- lbus_wd  in  8  write byte from controller.
- lbus_we  in  1  write byte valid, one byte per cycle.
- lbus_ful  out  1  do-not-write flag.
- lbus_rd  out  8  FIFO head byte (first-word fall-through).
- lbus_re  in  1  pop FIFO head.
- lbus_emp  out  1  FIFO empty.
- blk_addr  out  16  register address.
- blk_wdata  out  16  register write data.
- blk_wr  out  1  one-cycle write strobe.
- blk_rd  out  1  one-cycle read strobe.
- blk_rdata  in  16  register read data.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge):
  - state=IDLE; FIFO emptied.
  - blk_addr=0, blk_wdata=0, blk_wr=0, blk_rd=0, err=0.
  - lbus_emp=1, lbus_ful=0, lbus_rd=0x00.
  - Reset mid-command discards all partial bytes and queued read data.
- Command format:
  - Write: 0x01, addrH, addrL, dataH, dataL.
  - Read: 0x00, addrH, addrL.
  - Any other command byte received in IDLE is dropped, err is set, and state stays IDLE.
- States: IDLE, W_AH, W_AL, W_DH, W_DL, W_EXEC, R_AH, R_AL, R_EXEC, R_WAIT, R_PUSH_H, R_PUSH_L.
  - Each accepted byte advances exactly one state.
  - Non-byte cycles hold the current state.
- Write path:
  - The cycle after dataL is accepted, state=W_EXEC: blk_wr=1 for exactly one cycle with blk_addr/blk_wdata stable.
  - Next state IDLE.
  - A byte arriving in W_EXEC is treated as the next command byte.
- Read path:
  - After addrL is accepted, state goes to R_EXEC: blk_rd=1 for one cycle.
  - R_WAIT lasts RD_LAT-1 cycles; blk_rdata is sampled at the end of R_WAIT.
  - R_PUSH_H pushes rdata[15:8]; R_PUSH_L pushes rdata[7:0]; then IDLE.
  - Byte order is fixed: high byte first.
- lbus_ful = 1 when state is in {R_EXEC, R_WAIT, R_PUSH_H, R_PUSH_L}, or when FIFO count > DEPTH-2. This guarantees room for 2 bytes before a read starts.
- lbus_we while lbus_ful=1: byte dropped, err set, state unchanged.
- FIFO:
  - Count width is log2(DEPTH)+1.
  - lbus_emp = (count==0).
  - lbus_rd always shows the head byte; it is 0x00 when empty.
  - lbus_re with count==0 is ignored (no underflow, err unchanged).
  - Push and pop in the same cycle: count unchanged, head advances.
  - Pointers wrap modulo DEPTH.
- blk_addr/blk_wdata hold their last values between commands.
- err is cleared only by RST.

Optional Feature:
- Macro LBUS_TIMEOUT_EN.
- When defined:
  - A counter runs while state is W_AH..W_DL or R_AH..R_AL; it resets on each accepted byte.
  - When the counter reaches TIMEOUT, state returns to IDLE, partial bytes are discarded, and err is set.
  - No strobe is issued.
- When undefined: no counter is instantiated, and the parser waits indefinitely in mid-command states.

Test Plan:
- Write: bytes 01 12 34 AB CD on consecutive cycles -> blk_wr high exactly once, one cycle after CD, with blk_addr=0x1234 and blk_wdata=0xABCD; err=0.
- Read: bytes 00 00 0C, blk_rdata=0x5A3C valid RD_LAT cycles after blk_rd -> lbus_emp falls; pops give 0x5A then 0x3C; lbus_emp=1 afterwards; lbus_ful is 1 from R_EXEC through R_PUSH_L.
- Bad command / overflow: byte 0x07 in IDLE -> dropped, err=1. Then, with DEPTH=4, issue two reads without popping -> lbus_ful stays 1 after the second read. Any further lbus_we is dropped and the FIFO content of 4 bytes is intact.
- Simultaneous push and pop: pop on the exact cycle of R_PUSH_H -> count unchanged, order preserved. Pop when empty -> no change, err unchanged.
- Reset mid-command: send 01 12 34, assert RST for one cycle, then send 00 00 02 -> no blk_wr ever; a single read at address 0x0002.
- Timeout (LBUS_TIMEOUT_EN, TIMEOUT=16): send 01 12, then idle 16 cycles -> state IDLE, err=1. A following 00 00 04 performs a normal read.
